// File: rtl/i2s_clk_gen.sv
// I2S/TDM bit-clock and word-select generator with a programmable divide ratio.
// A new ratio is taken only at period boundaries, and a stop request parks sck low.
module i2s_clk_gen #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 64,
    parameter int SLOT_BITS   = 32,
    parameter int CHANNELS    = 2,
    parameter int MODE        = 0,
    localparam int BW         = $clog2(SLOT_BITS),
    localparam int CW         = $clog2(CHANNELS)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             sck,
    output logic             ws,
    output logic             sck_rise,
    output logic             sck_fall,
    output logic             frame_start,
    output logic [BW-1:0]    bit_idx,
    output logic [CW-1:0]    slot_idx,
    output logic             busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pend;
    logic             r_pend_v;
    logic             r_stop;
    logic             r_first;
    logic             r_sck;
    logic             r_ws;
    logic             r_rise;
    logic             r_fall;
    logic             r_fs;
    logic [BW-1:0]    r_bit;
    logic [CW-1:0]    r_slot;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_pend_nxt;
    logic             w_pend_v_nxt;
    logic             w_stop_nxt;
    logic             w_first_nxt;
    logic             w_sck_nxt;
    logic             w_ws_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_fs_nxt;
    logic [BW-1:0]    w_bit_nxt;
    logic [CW-1:0]    w_slot_nxt;
    logic             w_busy_nxt;

    logic [DIV_W-1:0] w_div_sat;
    logic [DIV_W-1:0] w_h;
    logic [DIV_W-1:0] w_cnt_inc;
    logic             w_last;
    logic             w_bit_last;
    logic             w_slot_last;

    assign w_div_sat   = (div_val < DIV_W'(2)) ? DIV_W'(2) : div_val;
    assign w_h         = r_div - (r_div >> 1);
    assign w_cnt_inc   = r_cnt + DIV_W'(1);
    assign w_last      = (r_cnt == r_div - DIV_W'(1));
    assign w_bit_last  = (r_bit == BW'(SLOT_BITS - 1));
    assign w_slot_last = (r_slot == CW'(CHANNELS - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_div_nxt    = r_div;
        w_pend_nxt   = r_pend;
        w_pend_v_nxt = r_pend_v;
        w_stop_nxt   = r_stop;
        w_first_nxt  = r_first;
        w_bit_nxt    = r_bit;
        w_slot_nxt   = r_slot;
        w_sck_nxt    = 1'b0;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        w_fs_nxt     = 1'b0;
        w_busy_nxt   = 1'b0;
        w_ws_nxt     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt    = '0;
                w_bit_nxt    = '0;
                w_slot_nxt   = '0;
                w_stop_nxt   = 1'b0;
                w_pend_v_nxt = 1'b0;
                if (div_load) begin
                    w_div_nxt = w_div_sat;
                end else if (r_pend_v) begin
                    w_div_nxt = r_pend;
                end
                if (en) begin
                    w_state_nxt = S_RUN;
                    w_sck_nxt   = 1'b1;
                    w_rise_nxt  = 1'b1;
                    w_fs_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_first_nxt = 1'b1;
                end
            end
            S_RUN: begin
                w_busy_nxt = 1'b1;
                if (!en) begin
                    w_stop_nxt = 1'b1;
                end
                if (div_load) begin
                    w_pend_nxt   = w_div_sat;
                    w_pend_v_nxt = 1'b1;
                end
                if (w_last) begin
                    // Period boundary: adopt any pending ratio, then restart or park
                    w_cnt_nxt = '0;
                    if (r_pend_v) begin
                        w_div_nxt = r_pend;
                    end
                    w_pend_v_nxt = div_load;
                    if (r_stop || !en) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_stop_nxt  = 1'b0;
                        w_bit_nxt   = '0;
                        w_slot_nxt  = '0;
                    end else begin
                        w_sck_nxt  = 1'b1;
                        w_rise_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_sck_nxt = (w_cnt_inc < w_h);
                    if (w_cnt_inc == w_h) begin
                        w_fall_nxt = 1'b1;
                        // The first fall after start stays inside bit 0
                        if (r_first) begin
                            w_first_nxt = 1'b0;
                        end else if (w_bit_last) begin
                            w_bit_nxt = '0;
                            if (w_slot_last) begin
                                w_slot_nxt = '0;
                                w_fs_nxt   = 1'b1;
                            end else begin
                                w_slot_nxt = r_slot + CW'(1);
                            end
                        end else begin
                            w_bit_nxt = r_bit + BW'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
        if (w_busy_nxt) begin
            if (MODE == 0) begin
                w_ws_nxt = (w_slot_nxt >= CW'(CHANNELS / 2));
            end else begin
                w_ws_nxt = (w_slot_nxt == '0) && (w_bit_nxt == '0);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_div    <= DIV_W'(DEFAULT_DIV);
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_stop   <= 1'b0;
            r_first  <= 1'b0;
            r_sck    <= 1'b0;
            r_ws     <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_fs     <= 1'b0;
            r_bit    <= '0;
            r_slot   <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_div    <= w_div_nxt;
            r_pend   <= w_pend_nxt;
            r_pend_v <= w_pend_v_nxt;
            r_stop   <= w_stop_nxt;
            r_first  <= w_first_nxt;
            r_sck    <= w_sck_nxt;
            r_ws     <= w_ws_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_fs     <= w_fs_nxt;
            r_bit    <= w_bit_nxt;
            r_slot   <= w_slot_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign sck         = r_sck;
    assign ws          = r_ws;
    assign sck_rise    = r_rise;
    assign sck_fall    = r_fall;
    assign frame_start = r_fs;
    assign bit_idx     = r_bit;
    assign slot_idx    = r_slot;
    assign busy        = r_busy;

endmodule

// File: tb/tb_i2s_clk_gen.sv
// Bench for i2s_clk_gen: period scoreboard on an I2S instance plus a TDM instance.
module tb_i2s_clk_gen;

    typedef struct {
        int h;
        int p;
    } per_t;

    typedef struct {
        logic [7:0] dv;
        int         h;
        int         l;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic       div_load = 1'b0;
    logic       sck, ws, sck_rise, sck_fall, frame_start, busy;
    logic [4:0] bit_idx;
    logic [0:0] slot_idx;

    logic       en1 = 1'b0;
    logic [7:0] div_val1 = 8'd0;
    logic       div_load1 = 1'b0;
    logic       sck1, ws1, rise1, fall1, fs1, busy1;
    logic [4:0] bit1;
    logic [2:0] slot1;

    int   n_chk = 0;
    int   n_fail = 0;
    per_t sb[$];
    vec_t vt[8];

    bit   in_run = 1'b0;
    int   hcnt = 0;
    int   pcnt = 0;

    bit   fr_on = 1'b0;
    int   fcyc = 0;
    logic ws_q = 1'b0;
    int   ws_t[$];
    int   fs_t[$];

    bit   m1_on = 1'b0;
    int   m1cyc = 0;
    int   hw = 0;
    int   r1 = 0;
    logic ws1_q = 1'b0;
    int   slot1_q = 0;
    int   w1r_t[$];
    int   w1w[$];

    always #5 clk = ~clk;

    i2s_clk_gen dut0 (
        .clk_in(clk), .rst(rst), .en(en), .div_val(div_val),
        .div_load(div_load), .sck(sck), .ws(ws), .sck_rise(sck_rise),
        .sck_fall(sck_fall), .frame_start(frame_start),
        .bit_idx(bit_idx), .slot_idx(slot_idx), .busy(busy)
    );

    i2s_clk_gen #(.CHANNELS(8), .MODE(1)) dut1 (
        .clk_in(clk), .rst(rst), .en(en1), .div_val(div_val1),
        .div_load(div_load1), .sck(sck1), .ws(ws1), .sck_rise(rise1),
        .sck_fall(fall1), .frame_start(fs1),
        .bit_idx(bit1), .slot_idx(slot1), .busy(busy1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int h, input int p, input int n);
        per_t e;
        e.h = h;
        e.p = p;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic sb_pop(input int h, input int p);
        per_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", p, 0);
        end else begin
            e = sb.pop_front();
            chk("per_high", h, e.h);
            chk("per_len", p, e.p);
        end
    endtask

    // Period monitor: high width and rise-to-rise length of every sck period
    always @(negedge clk) begin
        if (!busy) begin
            if (in_run) sb_pop(hcnt, pcnt);
            in_run = 1'b0;
        end else begin
            if (sck_rise) begin
                if (in_run) sb_pop(hcnt, pcnt);
                in_run = 1'b1;
                hcnt = 0;
                pcnt = 0;
            end
            if (in_run) begin
                pcnt++;
                if (sck) hcnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (fr_on && busy) begin
            fcyc++;
            if (ws != ws_q) begin
                ws_t.push_back(fcyc);
                chk("ws_on_fall", int'(sck_fall), 1);
            end
            ws_q = ws;
            if (frame_start) begin
                fs_t.push_back(fcyc);
                chk("fs_idx", int'({slot_idx, bit_idx}), 0);
                if (fs_t.size() > 1) chk("fs_ws_low", int'(ws), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (m1_on && busy1) begin
            m1cyc++;
            if (rise1 && sck1) r1++;
            if (ws1 && !ws1_q) begin
                chk("m1_fs_align", int'(fs1), 1);
                w1r_t.push_back(m1cyc);
                hw = 0;
            end
            if (fs1) chk("m1_fs_idx", int'({slot1, bit1}), 0);
            if (ws1) hw++;
            if (!ws1 && ws1_q) begin
                w1w.push_back(hw);
                chk("m1_ws_on_fall", int'(fall1), 1);
            end
            if (int'(slot1) != slot1_q)
                chk("m1_slot_seq", int'(slot1), (slot1_q + 1) % 8);
            ws1_q = ws1;
            slot1_q = int'(slot1);
        end
    end

    task automatic load(input logic [7:0] v);
        @(negedge clk);
        div_val = v;
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    task automatic wait_rises(input int n);
        int r = 0;
        int t = 0;
        while (r < n && t < 20000) begin
            @(negedge clk);
            t++;
            if (sck_rise) r++;
        end
        chk("rise_count", r, n);
    endtask

    task automatic stop_and_park();
        int t = 0;
        en = 1'b0;
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("park", int'(busy), 0);
    endtask

    task automatic run_periods(input int n);
        en = 1'b1;
        wait_rises(n);
        stop_and_park();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int t;
        vt[0] = '{8'd0,   1,   1};
        vt[1] = '{8'd1,   1,   1};
        vt[2] = '{8'd2,   1,   1};
        vt[3] = '{8'd3,   2,   1};
        vt[4] = '{8'd5,   3,   2};
        vt[5] = '{8'd7,   4,   3};
        vt[6] = '{8'd8,   4,   4};
        vt[7] = '{8'd255, 128, 127};

        repeat (3) @(negedge clk);
        chk("rst_outs0", int'({sck, ws, sck_rise, sck_fall, frame_start,
                               busy, bit_idx, slot_idx}), 0);
        chk("rst_outs1", int'({sck1, ws1, rise1, fall1, fs1, busy1,
                               bit1, slot1}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Start latency with the reset ratio of 64
        push(32, 64, 2);
        en = 1'b1;
        @(negedge clk);
        chk("lat_rise_fs", int'({sck, sck_rise, frame_start}), 7);
        chk("lat_busy", int'(busy), 1);
        @(negedge clk);
        chk("strobe_1cyc", int'({sck, sck_rise, frame_start}), 4);
        wait_rises(1);
        stop_and_park();

        // Frame timing at 64: 2048-cycle ws half periods, 4096-cycle frames
        fr_on = 1'b1;
        push(32, 64, 130);
        run_periods(130);
        fr_on = 1'b0;
        chk("fs_count", int'(fs_t.size() >= 3), 1);
        chk("ws_count", int'(ws_t.size() >= 4), 1);
        if (fs_t.size() >= 3) chk("frame_len", fs_t[2] - fs_t[1], 4096);
        if (ws_t.size() >= 4) begin
            chk("ws_half_a", ws_t[2] - ws_t[1], 2048);
            chk("ws_half_b", ws_t[3] - ws_t[2], 2048);
        end

        for (int i = 0; i < 8; i++) begin
            load(vt[i].dv);
            push(vt[i].h, vt[i].h + vt[i].l, 3);
            run_periods(3);
        end

        // Ratio change mid-high: current period stays 64, next ones are 8
        load(8'd64);
        push(32, 64, 1);
        push(4, 8, 3);
        en = 1'b1;
        wait_rises(1);
        repeat (10) @(negedge clk);
        div_val = 8'd8;
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        wait_rises(3);
        stop_and_park();

        // Stop in slot 1, park, then restart at slot 0 bit 0
        load(8'd2);
        push(1, 2, 40);
        run_periods(40);
        repeat (4) @(negedge clk);
        chk("park_state", int'({sck, busy, ws, bit_idx, slot_idx}), 0);
        push(1, 2, 1);
        en = 1'b1;
        @(negedge clk);
        chk("restart_strobes", int'({sck, sck_rise, frame_start}), 7);
        chk("restart_idx", int'({bit_idx, slot_idx}), 0);
        stop_and_park();

        // TDM instance: 8 slots of 32 bits at divide 4
        m1_on = 1'b1;
        @(negedge clk);
        div_val1 = 8'd4;
        div_load1 = 1'b1;
        @(negedge clk);
        div_load1 = 1'b0;
        en1 = 1'b1;
        repeat (3300) @(negedge clk);
        en1 = 1'b0;
        t = 0;
        while (busy1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        m1_on = 1'b0;
        chk("m1_park", int'(busy1), 0);
        chk("m1_nrises", r1, 825);
        chk("m1_nws", int'(w1r_t.size() >= 4 && w1w.size() >= 3), 1);
        if (w1r_t.size() >= 4) begin
            chk("m1_frame_a", w1r_t[2] - w1r_t[1], 1024);
            chk("m1_frame_b", w1r_t[3] - w1r_t[2], 1024);
        end
        if (w1w.size() >= 3) begin
            chk("m1_ws_w_a", w1w[1], 4);
            chk("m1_ws_w_b", w1w[2], 4);
        end

        // Reset mid-frame after loading 8; ratio returns to 64
        load(8'd8);
        push(4, 8, 19);
        push(1, 1, 1);
        en = 1'b1;
        wait_rises(20);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", int'({sck, ws, sck_rise, sck_fall, frame_start,
                                  busy, bit_idx, slot_idx}), 0);
        rst = 1'b0;
        en = 1'b0;
        @(negedge clk);
        push(32, 64, 2);
        run_periods(2);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
